// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner and iterative multiply/divide sequencer for the
// MIPS execute stage. Multiply is 1-bit/cycle shift-add, divide is 1-bit/cycle
// restoring; signed ops run on magnitudes and are corrected in a FIX cycle.
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             pipe_stall,
  output logic             stall_out,
  output logic             busy,
  output logic [WIDTH-1:0] mf_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_e;

  state_e             state_q, state_d;
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // opb holds the multiplicand or divisor magnitude
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;     // product / quotient needs negation
  logic               rneg_q, rneg_d;   // remainder takes the dividend sign
  logic               dz_q, dz_d;       // divide by zero, acc low holds raw rs
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, mf_q, mf_d;

  logic               muldiv_op, accept, sgn;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Decode, handshake and operand magnitudes
  always_comb begin
    muldiv_op = op_valid & (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU,
                                          F_MFHI, F_MTHI, F_MFLO, F_MTLO});
    busy      = (state_q != S_IDLE);
    stall_out = muldiv_op & busy;
    accept    = muldiv_op & ~busy & ~pipe_stall;
    sgn       = ~funct[0];
    rs_abs    = (sgn & rs_val[WIDTH-1]) ? -rs_val : rs_val;
    rt_abs    = (sgn & rt_val[WIDTH-1]) ? -rt_val : rt_val;
  end

  // One iteration step of each datapath plus the sign fix-up results
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, opb_q};
    prod_fix  = neg_q ? -acc_q : acc_q;
    q_fix     = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_fix     = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state, datapath and HI/LO update
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mf_d     = mf_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (funct)
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              is_div_d = funct[1];
              neg_d    = sgn & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
              rneg_d   = sgn & rs_val[WIDTH-1];
              opb_d    = rt_abs;
              cnt_d    = CW'(WIDTH-1);
              dz_d     = funct[1] & (rt_val == '0);
              if (funct[1] && rt_val == '0) begin
                acc_d   = {{WIDTH{1'b0}}, rs_val};
                state_d = S_FIX;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, rs_abs};
                state_d = S_ITER;
              end
            end
            F_MFHI:  mf_d = hi_q;
            F_MFLO:  mf_d = lo_q;
            F_MTHI:  hi_d = rs_val;
            F_MTLO:  lo_d = rs_val;
            default: ;
          endcase
        end
      end
      S_ITER: begin
        if (is_div_q) begin
          if (div_trial[WIDTH])
            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          else
            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        if (dz_q) begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = {WIDTH{1'b1}};
        end else if (is_div_q) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mf_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mf_q     <= mf_d;
    end
  end

  // MF result is combinational on accept, otherwise the last value read
  always_comb begin
    if (accept && funct == F_MFHI)      mf_data = hi_q;
    else if (accept && funct == F_MFLO) mf_data = lo_q;
    else                                mf_data = mf_q;
    hi_out = hi_q;
    lo_out = lo_q;
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: directed cases with literal results plus randomized
// op streams, all checked every cycle against an arithmetic reference model.
module tb_muldiv_ctrl;

  logic        clk, rst, op_valid, pipe_stall;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val;
  logic        stall_out, busy;
  logic [31:0] mf_data, hi_out, lo_out;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .pipe_stall(pipe_stall),
    .stall_out(stall_out), .busy(busy), .mf_data(mf_data),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_run = 0, n_fail = 0;
  // reference model: architectural HI/LO, last MF value, busy cycles left
  logic [31:0] m_hi = '0, m_lo = '0, m_mf = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;
  logic [31:0] smp_mf;
  logic        smp_stall;

  function automatic bit is_md(input logic [5:0] f);
    return f inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Arithmetic result of a multiply/divide and how long the unit stays busy
  task automatic model_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                          output logic [31:0] h, output logic [31:0] l, output int len);
    longint sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(rs));
    sb = longint'($signed(rt));
    ua = {32'h0, rs};
    ub = {32'h0, rt};
    len = 33;
    h = '0; l = '0;
    case (f)
      6'h18: begin ps = sa * sb; h = ps[63:32]; l = ps[31:0]; end
      6'h19: begin pu = ua * ub; h = pu[63:32]; l = pu[31:0]; end
      6'h1A, 6'h1B: begin
        if (rt == 32'h0) begin
          h = rs; l = 32'hFFFF_FFFF; len = 1;
        end else if (f == 6'h1A) begin
          ps = sa / sb; l = ps[31:0];
          ps = sa % sb; h = ps[31:0];
        end else begin
          pu = ua / ub; l = pu[31:0];
          pu = ua % ub; h = pu[31:0];
        end
      end
      default: ;
    endcase
  endtask

  // One clock cycle: compare DUT outputs to the model mid-cycle, advance the model
  task automatic step(output bit acc);
    bit          op, a;
    logic [31:0] emf, h, l;
    int          len;
    @(negedge clk);
    op  = op_valid && is_md(funct);
    a   = op && (m_left == 0) && !pipe_stall;
    emf = (a && funct == 6'h10) ? m_hi : (a && funct == 6'h12) ? m_lo : m_mf;
    smp_mf    = mf_data;
    smp_stall = stall_out;
    chk("busy",      32'(busy),      32'(m_left > 0));
    chk("stall_out", 32'(stall_out), 32'(op && m_left > 0));
    chk("hi_out",    hi_out, m_hi);
    chk("lo_out",    lo_out, m_lo);
    chk("mf_data",   mf_data, emf);
    acc = a && !rst;
    if (rst) begin
      m_hi = '0; m_lo = '0; m_mf = '0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (a) begin
      case (funct)
        6'h10: m_mf = m_hi;
        6'h12: m_mf = m_lo;
        6'h11: m_hi = rs_val;
        6'h13: m_lo = rs_val;
        default: begin
          model_op(funct, rs_val, rt_val, h, l, len);
          p_hi = h; p_lo = l; m_left = len;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                       input bit rps);
    bit acc;
    int n;
    op_valid = 1'b1; funct = f; rs_val = rs; rt_val = rt;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      pipe_stall = rps ? ($urandom_range(0, 3) == 0) : 1'b0;
      step(acc);
      n++;
    end
    op_valid = 1'b0; pipe_stall = 1'b0;
    if (!acc) chk("issue_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_idle();
    bit acc;
    int n;
    n = 0;
    while (m_left > 0 && n < 100) begin step(acc); n++; end
    chk("idle", 32'(busy), 32'd0);
  endtask

  task automatic count_busy(output int cnt);
    bit acc;
    cnt = 0;
    while (busy && cnt < 100) begin step(acc); cnt++; end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit          acc;
    int          cnt;
    logic [5:0]  f;
    logic [5:0]  ftab [12];
    ftab = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h11, 6'h12, 6'h13,
             6'h20, 6'h00, 6'h14, 6'h1C};
    rst = 1'b1; op_valid = 1'b0; pipe_stall = 1'b0;
    funct = '0; rs_val = '0; rt_val = '0;
    repeat (2) @(posedge clk);
    #1;
    step(acc);                      // reset state compared against zeroed model
    rst = 1'b0;
    chk("reset_hi", hi_out, 32'h0);
    chk("reset_mf", mf_data, 32'h0);

    // MULTU all-ones
    issue(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    count_busy(cnt);
    chk("multu_busy_cycles", 32'(cnt), 32'd33);
    chk("multu_hi", hi_out, 32'hFFFF_FFFE);
    chk("multu_lo", lo_out, 32'h0000_0001);

    // signed multiply and divide
    issue(6'h18, 32'hFFFF_FFFD, 32'h5, 1'b0);
    wait_idle();
    chk("mult_hi", hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", lo_out, 32'hFFFF_FFF1);
    issue(6'h1A, 32'hFFFF_FFF9, 32'h2, 1'b0);
    wait_idle();
    chk("div_lo", lo_out, 32'hFFFF_FFFD);
    chk("div_hi", hi_out, 32'hFFFF_FFFF);

    // divide by zero and the signed overflow case
    issue(6'h1B, 32'h0000_1234, 32'h0, 1'b0);
    count_busy(cnt);
    chk("div0_busy_cycles", 32'(cnt), 32'd1);
    chk("div0_hi", hi_out, 32'h0000_1234);
    chk("div0_lo", lo_out, 32'hFFFF_FFFF);
    issue(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    chk("divovf_lo", lo_out, 32'h8000_0000);
    chk("divovf_hi", hi_out, 32'h0);

    // MFLO held behind an in-flight MULT
    issue(6'h18, 32'd6, 32'd7, 1'b0);
    step(acc);
    op_valid = 1'b1; funct = 6'h12; rs_val = '0; rt_val = '0;
    cnt = 0; acc = 1'b0;
    while (!acc && cnt < 100) begin
      step(acc);
      if (smp_stall) cnt++;
    end
    op_valid = 1'b0;
    chk("mflo_stall_cycles", 32'(cnt), 32'd32);
    chk("mflo_data", smp_mf, 32'h0000_002A);
    chk("mflo_stall_end", 32'(smp_stall), 32'd0);

    // MTHI blocked by pipe_stall, then written
    op_valid = 1'b1; funct = 6'h11; rs_val = 32'hAAAA_5555; pipe_stall = 1'b1;
    step(acc); step(acc);
    chk("mthi_held_hi", hi_out, 32'h0);
    pipe_stall = 1'b0;
    step(acc);
    op_valid = 1'b0;
    chk("mthi_hi", hi_out, 32'hAAAA_5555);
    chk("mthi_lo", lo_out, 32'h0000_002A);

    // reset in the middle of an iteration
    issue(6'h18, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (10) step(acc);
    rst = 1'b1;
    step(acc);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    issue(6'h19, 32'd2, 32'd3, 1'b0);
    wait_idle();
    chk("post_rst_lo", lo_out, 32'd6);

    // randomized op stream, ops often arrive while busy
    for (int i = 0; i < 160; i++) begin
      f = ftab[$urandom_range(0, 11)];
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; step(acc); rst = 1'b0;
      end
      if (is_md(f)) begin
        issue(f, pick(), pick(), 1'b1);
      end else begin
        op_valid = 1'b1; funct = f; rs_val = $urandom; rt_val = $urandom;
        pipe_stall = $urandom_range(0, 1);
        step(acc);
        op_valid = 1'b0; pipe_stall = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step(acc);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
